// File: rtl/topk_pkg.sv
// Shared types for the top-k pop queue: default widths, data/count types and per-slot operations.
package topk_pkg;

    localparam int unsigned TOPK_DATA_WIDTH = 32;
    localparam int unsigned TOPK_DEPTH      = 8;
    localparam int unsigned TOPK_CNT_W      = $clog2(TOPK_DEPTH + 1);

    typedef logic [TOPK_DATA_WIDTH-1:0] data_t;
    typedef logic [TOPK_CNT_W-1:0]      cnt_t;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        SHIFT_DN = 2'd1,
        SHIFT_UP = 2'd2,
        LOAD_DIN = 2'd3
    } slot_op_e;

endpackage

// File: rtl/topk_pop_queue_if.sv
// Producer/consumer bundle of the top-k pop queue; master = environment side, slave = queue.
interface topk_pop_queue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 4
);
    logic                  clear;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] din;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic [CNT_W-1:0]      count;
    logic                  evict;

    modport master (
        output clear, in_valid, din, out_ready,
        input  out_valid, dout, count, evict
    );

    modport slave (
        input  clear, in_valid, din, out_ready,
        output out_valid, dout, count, evict
    );
endinterface

// File: rtl/topk_slot_ctl.sv
// Chooses the next-cycle operation of one sorted slot from local compare results.
module topk_slot_ctl
    import topk_pkg::*;
#(
    parameter bit FIRST = 1'b0
) (
    input  logic     i_push,
    input  logic     i_pop,
    input  logic     i_ge_self,
    input  logic     i_ge_prev,
    input  logic     i_ge_next,
    output slot_op_e o_op_c
);

    // ge_* mean "that slot is valid and holds a value >= din"; prefixes are contiguous
    always_comb begin
        o_op_c = HOLD;
        if (i_push && i_pop) begin
            if (i_ge_next)
                o_op_c = SHIFT_UP;
            else if (i_ge_self || FIRST)
                o_op_c = LOAD_DIN;
        end else if (i_push) begin
            if (!i_ge_self)
                o_op_c = i_ge_prev ? LOAD_DIN : SHIFT_DN;
        end else if (i_pop) begin
            o_op_c = SHIFT_UP;
        end
    end

endmodule

// File: rtl/topk_pop_queue.sv
// Keeps the DEPTH largest values of a stream in a descending register array; pops largest-first.
module topk_pop_queue
    import topk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           resetn,
    topk_pop_queue_if.slave bus
);

    logic [DATA_WIDTH-1:0] r_entry     [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [CNT_W-1:0]      r_count;
    logic                  r_evict;

    logic [DATA_WIDTH-1:0] w_nxt       [DEPTH];
    logic [DATA_WIDTH-1:0] w_dn_src    [DEPTH];
    logic [DATA_WIDTH-1:0] w_up_src    [DEPTH];
    slot_op_e              w_op        [DEPTH];
    logic [DEPTH+1:0]      w_ge_ext;
    logic [DEPTH-1:0]      w_valid_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_evict_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;

    assign w_push = bus.in_valid && !bus.clear;
    assign w_pop  = bus.out_ready && (r_count != '0) && !bus.clear;
    assign w_full = (r_count == CNT_W'(DEPTH));

    // Sentinels: above slot 0 counts as ">= din", below the last slot does not
    assign w_ge_ext[0]       = 1'b1;
    assign w_ge_ext[DEPTH+1] = 1'b0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign w_ge_ext[g+1] = r_valid[g] && (r_entry[g] >= bus.din);

        if (g == 0) begin : g_first
            assign w_dn_src[g] = bus.din;
        end else begin : g_mid
            assign w_dn_src[g] = r_entry[g-1];
        end

        if (g == DEPTH - 1) begin : g_last
            assign w_up_src[g] = '0;
        end else begin : g_body
            assign w_up_src[g] = r_entry[g+1];
        end

        topk_slot_ctl #(
            .FIRST (g == 0)
        ) u_slot_ctl (
            .i_push    (w_push),
            .i_pop     (w_pop),
            .i_ge_self (w_ge_ext[g+1]),
            .i_ge_prev (w_ge_ext[g]),
            .i_ge_next (w_ge_ext[g+2]),
            .o_op_c    (w_op[g])
        );
    end

    always_comb begin
        w_count_nxt = r_count;
        w_evict_nxt = 1'b0;
        if (bus.clear) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            if (w_full)
                w_evict_nxt = 1'b1;
            else
                w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // One mux per slot; valid bits follow the new occupancy so they stay contiguous
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_nxt[i] = r_entry[i];
            if (bus.clear) begin
                w_nxt[i] = '0;
            end else begin
                case (w_op[i])
                    SHIFT_DN: w_nxt[i] = w_dn_src[i];
                    SHIFT_UP: w_nxt[i] = w_up_src[i];
                    LOAD_DIN: w_nxt[i] = bus.din;
                    default:  w_nxt[i] = r_entry[i];
                endcase
            end
            w_valid_nxt[i] = (CNT_W'(i) < w_count_nxt);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_entry[i] <= '0;
            r_valid <= '0;
            r_count <= '0;
            r_evict <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_entry[i] <= w_nxt[i];
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            r_evict <= w_evict_nxt;
        end
    end

    assign bus.out_valid = (r_count != '0);
    assign bus.dout      = r_valid[0] ? r_entry[0] : '0;
    assign bus.count     = r_count;
    assign bus.evict     = r_evict;

endmodule

// File: tb/tb_topk_pop_queue.sv
// Self-checking bench for topk_pop_queue: directed scenarios on DEPTH=8/4 plus a randomized scoreboard run.
module tb_topk_pop_queue;
    import topk_pkg::*;

    typedef int unsigned uq_t[$];

    localparam int unsigned DW   = TOPK_DATA_WIDTH;
    localparam int unsigned CW4  = 3;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    topk_pop_queue_if #(.DATA_WIDTH(DW), .CNT_W(TOPK_CNT_W)) b8 ();
    topk_pop_queue_if #(.DATA_WIDTH(DW), .CNT_W(CW4))        b4 ();

    topk_pop_queue #(.DATA_WIDTH(DW), .DEPTH(TOPK_DEPTH), .CNT_W(TOPK_CNT_W)) u_dut8 (
        .clk(clk), .resetn(resetn), .bus(b8)
    );
    topk_pop_queue #(.DATA_WIDTH(DW), .DEPTH(4), .CNT_W(CW4)) u_dut4 (
        .clk(clk), .resetn(resetn), .bus(b4)
    );

    // Reference: a plain sorted list; pop the head, append din, re-sort, drop the smallest when over capacity
    function automatic void model_step(input uq_t qi, input int dep, input bit push, input int unsigned d,
                                       input bit pop, input bit clr, output uq_t qo, output bit ev);
        qo = qi;
        ev = 1'b0;
        if (clr) begin
            qo.delete();
            return;
        end
        if (pop && qo.size() > 0)
            void'(qo.pop_front());
        if (push) begin
            qo.push_back(d);
            qo.rsort();
            if (qo.size() > dep) begin
                void'(qo.pop_back());
                ev = 1'b1;
            end
        end
    endfunction

    task automatic cyc8(input bit push, input data_t d, input bit pop, input bit clr);
        @(negedge clk);
        b8.in_valid = push; b8.din = d; b8.out_ready = pop; b8.clear = clr;
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.clear = 1'b0;
    endtask

    task automatic cyc4(input bit push, input data_t d, input bit pop, input bit clr);
        @(negedge clk);
        b4.in_valid = push; b4.din = d; b4.out_ready = pop; b4.clear = clr;
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.clear = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        b8.clear = 0; b8.in_valid = 0; b8.din = '0; b8.out_ready = 0;
        b4.clear = 0; b4.in_valid = 0; b4.din = '0; b4.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (b8.out_valid !== 1'b0 || b8.dout !== '0 || b8.count !== '0 || b8.evict !== 1'b0) begin
            n_err++; $display("FAIL reset_state8: got v=%0b d=%0d c=%0d e=%0b want 0/0/0/0", b8.out_valid, b8.dout, b8.count, b8.evict);
        end
        n_cmp++; if (b4.out_valid !== 1'b0 || b4.count !== '0) begin
            n_err++; $display("FAIL reset_state4: got v=%0b c=%0d want 0/0", b4.out_valid, b4.count);
        end
        @(negedge clk) resetn = 1'b1;
        for (int i = 0; i < 5; i++) cyc8(1'b1, data_t'(100 + i), 1'b0, 1'b0);
        n_cmp++; if (b8.count !== TOPK_CNT_W'(5) || b8.dout !== data_t'(104)) begin
            n_err++; $display("FAIL reset_fill: got c=%0d d=%0d want 5/104", b8.count, b8.dout);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (b8.out_valid !== 1'b0 || b8.dout !== '0 || b8.count !== '0) begin
            n_err++; $display("FAIL reset_async: got v=%0b d=%0d c=%0d want 0/0/0", b8.out_valid, b8.dout, b8.count);
        end
        @(negedge clk) resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc8(1'b0, '0, 1'b1, 1'b0);
            n_cmp++; if (b8.out_valid !== 1'b0 || b8.count !== '0 || b8.dout !== '0 || b8.evict !== 1'b0) begin
                n_err++; $display("FAIL pop_empty: got v=%0b c=%0d d=%0d e=%0b want 0/0/0/0", b8.out_valid, b8.count, b8.dout, b8.evict);
            end
        end
        cyc8(1'b1, data_t'(77), 1'b0, 1'b0);
        n_cmp++; if (b8.dout !== data_t'(77) || b8.count !== TOPK_CNT_W'(1)) begin
            n_err++; $display("FAIL first_after_reset: got d=%0d c=%0d want 77/1", b8.dout, b8.count);
        end
        cyc8(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_sorted_insert();
        int unsigned vin [4] = '{5, 9, 5, 2};
        int unsigned vexp[4] = '{9, 5, 5, 2};
        for (int i = 0; i < 4; i++) begin
            cyc8(1'b1, data_t'(vin[i]), 1'b0, 1'b0);
            n_cmp++; if (b8.count !== TOPK_CNT_W'(i + 1) || b8.evict !== 1'b0) begin
                n_err++; $display("FAIL ins_count[%0d]: got c=%0d e=%0b want %0d/0", i, b8.count, b8.evict, i + 1);
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (b8.dout !== data_t'(vexp[k]) || b8.count !== TOPK_CNT_W'(4 - k) || b8.out_valid !== 1'b1) begin
                n_err++; $display("FAIL ins_pop[%0d]: got d=%0d c=%0d v=%0b want %0d/%0d/1", k, b8.dout, b8.count, b8.out_valid, vexp[k], 4 - k);
            end
            cyc8(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (b8.out_valid !== 1'b0 || b8.count !== '0 || b8.dout !== '0) begin
            n_err++; $display("FAIL ins_drained: got v=%0b c=%0d d=%0d want 0/0/0", b8.out_valid, b8.count, b8.dout);
        end
    endtask

    task automatic test_overflow();
        int unsigned vin[4] = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) begin
            cyc4(1'b1, data_t'(vin[i]), 1'b0, 1'b0);
            n_cmp++; if (b4.evict !== 1'b0) begin
                n_err++; $display("FAIL ovf_fill_evict[%0d]: got %0b want 0", i, b4.evict);
            end
        end
        n_cmp++; if (b4.count !== CW4'(4) || b4.dout !== data_t'(40)) begin
            n_err++; $display("FAIL ovf_full: got c=%0d d=%0d want 4/40", b4.count, b4.dout);
        end
        cyc4(1'b1, data_t'(25), 1'b0, 1'b0);
        n_cmp++; if (b4.evict !== 1'b1 || b4.count !== CW4'(4) || b4.dout !== data_t'(40)) begin
            n_err++; $display("FAIL ovf_push25: got e=%0b c=%0d d=%0d want 1/4/40", b4.evict, b4.count, b4.dout);
        end
        cyc4(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (b4.evict !== 1'b0) begin
            n_err++; $display("FAIL ovf_evict_clear: got %0b want 0", b4.evict);
        end
        cyc4(1'b1, data_t'(1), 1'b0, 1'b0);
        n_cmp++; if (b4.evict !== 1'b1 || b4.count !== CW4'(4)) begin
            n_err++; $display("FAIL ovf_push1: got e=%0b c=%0d want 1/4", b4.evict, b4.count);
        end
    endtask

    task automatic test_push_pop();
        int unsigned vexp[4] = '{30, 25, 20, 5};
        cyc4(1'b1, data_t'(50), 1'b1, 1'b0);
        n_cmp++; if (b4.dout !== data_t'(50) || b4.count !== CW4'(4) || b4.evict !== 1'b0) begin
            n_err++; $display("FAIL pp_push50: got d=%0d c=%0d e=%0b want 50/4/0", b4.dout, b4.count, b4.evict);
        end
        cyc4(1'b1, data_t'(5), 1'b1, 1'b0);
        n_cmp++; if (b4.dout !== data_t'(30) || b4.count !== CW4'(4) || b4.evict !== 1'b0) begin
            n_err++; $display("FAIL pp_push5: got d=%0d c=%0d e=%0b want 30/4/0", b4.dout, b4.count, b4.evict);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (b4.dout !== data_t'(vexp[k])) begin
                n_err++; $display("FAIL pp_drain[%0d]: got %0d want %0d", k, b4.dout, vexp[k]);
            end
            cyc4(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (b4.count !== '0 || b4.out_valid !== 1'b0) begin
            n_err++; $display("FAIL pp_empty: got c=%0d v=%0b want 0/0", b4.count, b4.out_valid);
        end
    endtask

    task automatic test_clear();
        for (int i = 1; i <= 3; i++) cyc8(1'b1, data_t'(i), 1'b0, 1'b0);
        cyc8(1'b1, data_t'(7), 1'b1, 1'b1);
        n_cmp++; if (b8.count !== '0 || b8.out_valid !== 1'b0 || b8.evict !== 1'b0 || b8.dout !== '0) begin
            n_err++; $display("FAIL clr_prio: got c=%0d v=%0b e=%0b d=%0d want 0/0/0/0", b8.count, b8.out_valid, b8.evict, b8.dout);
        end
        cyc8(1'b1, data_t'(7), 1'b0, 1'b0);
        n_cmp++; if (b8.dout !== data_t'(7) || b8.count !== TOPK_CNT_W'(1)) begin
            n_err++; $display("FAIL clr_push7: got d=%0d c=%0d want 7/1", b8.dout, b8.count);
        end
    endtask

    task automatic test_back_to_back();
        uq_t         m;
        uq_t         mn;
        bit          ev;
        bit          push, pop, clr;
        int unsigned d;
        int unsigned exp_d;
        int          pushes = 0;
        int          iter   = 0;
        cyc4(1'b0, '0, 1'b0, 1'b1);
        m.delete();
        while (pushes < 200 && iter < 2000) begin
            push = ($urandom_range(0, 99) < 70);
            pop  = ($urandom_range(0, 99) < 45);
            clr  = ($urandom_range(0, 99) == 0);
            d    = $urandom_range(0, 40);
            if (iter % 97 == 50) d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            if (push) pushes++;
            iter++;
            model_step(m, 4, push, d, pop, clr, mn, ev);
            m = mn;
            cyc4(push, data_t'(d), pop, clr);
            exp_d = (m.size() > 0) ? m[0] : 0;
            n_cmp++; if (b4.count !== CW4'(m.size()) || b4.out_valid !== (m.size() > 0)) begin
                n_err++; $display("FAIL b2b_count[%0d]: got c=%0d v=%0b want %0d", iter, b4.count, b4.out_valid, m.size());
            end
            n_cmp++; if (b4.dout !== data_t'(exp_d)) begin
                n_err++; $display("FAIL b2b_dout[%0d]: got %0d want %0d", iter, b4.dout, exp_d);
            end
            n_cmp++; if (b4.evict !== ev) begin
                n_err++; $display("FAIL b2b_evict[%0d]: got %0b want %0b", iter, b4.evict, ev);
            end
        end
        n_cmp++; if (pushes < 200) begin
            n_err++; $display("FAIL b2b_budget: got %0d pushes want 200", pushes);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sorted_insert();
        test_overflow();
        test_push_pop();
        test_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/topk_pop_queue.md
Name: topk_pop_queue

Overview:
- Reader-side counterpart to the team's streaming order-statistic trackers. Instead of emitting a running statistic, it keeps the DEPTH largest values from an input stream and lets a consumer pop them largest-first.
- Values are held in a descending-sorted register array and updated in one cycle.
- Sits between a value producer (always accepted) and a downstream consumer with valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, width of unsigned data values
- DEPTH, 8, number of retained candidates; must be >= 2
- CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush; discards all held entries
- in_valid  input  1  din carries a new candidate this cycle (always accepted; no in_ready)
- din  input  DATA_WIDTH  unsigned candidate value
- out_valid  output  1  queue non-empty; dout is meaningful
- out_ready  input  1  consumer pops head when out_valid && out_ready
- dout  output  DATA_WIDTH  current largest held value (head, entry[0])
- count  output  CNT_W  number of held entries, 0..DEPTH
- evict  output  1  registered one-cycle pulse: a value was lost due to a full array

Behaviour:
- Reset (resetn low, async):
  - all entries 0, all entry-valid bits 0, count=0, evict=0.
  - out_valid=0 and dout=0 immediately.
- Storage:
  - entry[0..DEPTH-1], sorted descending, plus valid bits. Valid entries are contiguous from index 0.
  - dout = entry[0] when count>0, else 0 (combinational from registers).
  - out_valid = (count!=0).
- Push only (in_valid, no pop):
  - din is inserted after all valid entries >= din. Ties go behind existing equal values; each repeat is a separate candidate.
  - Entries below the insertion point shift down one slot.
  - Not full: count+1.
  - Full and din > entry[DEPTH-1]: the old entry[DEPTH-1] is dropped, evict=1 next cycle, count unchanged.
  - Full and din <= entry[DEPTH-1]: din is discarded, evict=1, array unchanged.
- Pop only (out_valid && out_ready, no in_valid):
  - All entries shift up one slot; the last valid bit clears; count-1.
  - Pop while empty is ignored.
- Push and pop in the same cycle:
  - The head is removed first, then din is inserted into the remaining entries.
  - count unchanged; never evicts.
  - If din >= every remaining entry, din becomes the new head.
  - If the queue was empty, the pop is ignored and this is a plain push.
- Latency:
  - A pushed value is visible on dout/count the cycle after acceptance.
  - A pop takes effect on the next edge.
  - No combinational path from din or out_ready to dout.
- clear:
  - Highest priority synchronous event: empties the array, count=0, evict=0 next cycle.
  - Any push or pop in the same cycle is ignored.
- Async reset mid-operation aborts everything; the first push after release lands at entry[0].
- Arithmetic:
  - Comparisons are unsigned, full DATA_WIDTH.
  - Insertion position is a per-slot parallel compare (no iteration); the shift network is one mux per slot.
- evict is cleared every cycle it is not set.

Decomposition:
- Package topk_pkg:
  - typedef data_t (logic [DATA_WIDTH-1:0]) and cnt_t.
  - enum slot_op_e {HOLD, SHIFT_DN, SHIFT_UP, LOAD_DIN}.
- One sub-module, topk_slot_ctl (combinational):
  - Per-slot inputs: compare results and op flags.
  - Output: slot_op_e for that slot.
  - Instantiated DEPTH times with generate.
- The top level holds the register array, count and evict.

Test Plan:
- Reset and empty: resetn low mid-stream with count=5 -> out_valid=0, dout=0, count=0 asynchronously. out_ready pulses while empty -> no change.
- Sorted insert with repeats: push 5,9,5,2 (DEPTH=8), then pop four times -> dout sequence 9,5,5,2. count goes 4→0; out_valid drops after the last pop.
- Overflow with DEPTH=4:
  - Push 10,20,30,40 -> count=4.
  - Push 25 -> evict pulse; contents 40,30,25,20.
  - Push 1 -> evict pulse; contents unchanged.
- Simultaneous push/pop with DEPTH=4 holding 40,30,25,20:
  - Push 50 with pop -> contents 50,30,25,20, count=4, no evict.
  - Push 5 with pop on 50,30,25,20 -> contents 30,25,20,5.
- Clear precedence: hold 3 entries, assert clear with in_valid=1 (din=7) and out_ready=1 -> next cycle count=0, out_valid=0. Then push 7 -> dout=7 one cycle later.
- Back-to-back stream: push random 200 values with random pops, compared against a scoreboard sorted model -> dout, count and evict match every cycle.
